key_debouncer: RTL and testbench

Parametrised multi-channel debouncer for switch and push-button inputs, sitting between the raw board pins and all downstream control logic. Each channel is synchronised to `clk` and sampled on a shared prescaled tick. The filtered output of a channel changes only after the input has held a new level for `STABLE` consecutive tick samples. Per-channel one-cycle rise and fall pulses are produced for edge-triggered consumers such as mode stepping and map-parameter increment.

---
 rtl/key_debouncer.sv | 85 ++++++++
 tb/tb_key_debouncer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// Multi-channel key debouncer: two-flop synchroniser, shared prescaled sample tick,
// per-channel stability counter, registered level and one-clk rise/fall pulses.
module key_debouncer #(
  parameter int unsigned N       = 18,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned STABLE  = 4,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_out,
  output logic [N-1:0] key_rise,
  output logic [N-1:0] key_fall,
  output logic         tick
);

  localparam int unsigned       CW       = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(STABLE - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = '1;

  logic [N-1:0]         s1_q, s1_d;
  logic [N-1:0]         s2_q, s2_d;
  logic [N-1:0]         out_q, out_d;
  logic [N-1:0]         rise_q, rise_d;
  logic [N-1:0]         fall_q, fall_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick_q, tick_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;

  // tick_q is registered from the next prescaler value, so it is high exactly
  // while div_q holds its terminal count.
  always_comb begin
    s1_d   = key_in;
    s2_d   = s1_q;
    div_d  = div_q + DIV_W'(1);
    tick_d = (div_d == DIV_LAST);
    out_d  = out_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    if (tick_q) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (s2_q[i] == out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          out_d[i]  = s2_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= {N{RST_VAL}};
      s2_q   <= {N{RST_VAL}};
      out_q  <= {N{RST_VAL}};
      rise_q <= '0;
      fall_q <= '0;
      div_q  <= '0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      div_q  <= div_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
    end
  end

  assign key_out  = out_q;
  assign key_rise = rise_q;
  assign key_fall = fall_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer: N=4, DIV_W=2, STABLE=3 main instance plus an
// RST_VAL=1, STABLE=1 variant instance.
module tb_key_debouncer;

  logic       clk;
  logic       rst, rst_v;
  logic [3:0] key_in, key_out, key_rise, key_fall;
  logic       tick;
  logic [3:0] key_in_v, key_out_v, key_rise_v, key_fall_v;
  logic       tick_v;

  int n_vec = 0;
  int n_err = 0;
  int rise_cnt [4];
  int fall_cnt [4];

  key_debouncer #(.N(4), .DIV_W(2), .STABLE(3), .RST_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_out(key_out),
    .key_rise(key_rise), .key_fall(key_fall), .tick(tick)
  );

  key_debouncer #(.N(4), .DIV_W(2), .STABLE(1), .RST_VAL(1'b1)) dut_v (
    .clk(clk), .rst(rst_v), .key_in(key_in_v), .key_out(key_out_v),
    .key_rise(key_rise_v), .key_fall(key_fall_v), .tick(tick_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  end

  // Pulse counters for the main instance, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (key_rise[i] === 1'b1) rise_cnt[i] = rise_cnt[i] + 1;
      if (key_fall[i] === 1'b1) fall_cnt[i] = fall_cnt[i] + 1;
    end
  end

  // Advance to the next falling edge at which tick is high (bounded).
  task automatic wait_tick;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 16);
    n_vec++;
    if (tick !== 1'b1) begin
      n_err++;
      $display("FAIL wait_tick: tick=%b required 1 within 16 clk", tick);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic test_reset;
    rst = 1'b0; rst_v = 1'b0; key_in = 4'hF; key_in_v = 4'hF;
    repeat (3) @(negedge clk);
    n_vec++; if (key_out !== 4'h0)  begin n_err++; $display("FAIL reset_key_out: got %h required 0", key_out); end
    n_vec++; if (key_rise !== 4'h0) begin n_err++; $display("FAIL reset_rise: got %h required 0", key_rise); end
    n_vec++; if (key_fall !== 4'h0) begin n_err++; $display("FAIL reset_fall: got %h required 0", key_fall); end
    n_vec++; if (tick !== 1'b0)     begin n_err++; $display("FAIL reset_tick: got %b required 0", tick); end
    n_vec++; if (key_out_v !== 4'hF) begin n_err++; $display("FAIL reset_v_key_out: got %h required f", key_out_v); end
    key_in = 4'h0;
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_vec++;
      if (tick !== ((k % 4) == 3)) begin
        n_err++;
        $display("FAIL reset_tick_cadence: edge %0d tick=%b required %b", k, tick, ((k % 4) == 3));
      end
    end
  endtask

  task automatic test_clean_press;
    wait_tick();
    key_in[0] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      wait_tick();
      n_vec++; if (key_out !== 4'h0) begin n_err++; $display("FAIL press_hold: tick %0d key_out=%h required 0", t, key_out); end
    end
    @(negedge clk);
    n_vec++; if (key_out !== 4'h1)  begin n_err++; $display("FAIL press_key_out: got %h required 1", key_out); end
    n_vec++; if (key_rise !== 4'h1) begin n_err++; $display("FAIL press_rise: got %h required 1", key_rise); end
    n_vec++; if (key_fall !== 4'h0) begin n_err++; $display("FAIL press_fall: got %h required 0", key_fall); end
    @(negedge clk);
    n_vec++; if (key_rise !== 4'h0) begin n_err++; $display("FAIL press_rise_width: got %h required 0", key_rise); end
    n_vec++; if (key_out !== 4'h1)  begin n_err++; $display("FAIL press_key_out_held: got %h required 1", key_out); end

    wait_tick();
    key_in[0] = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      wait_tick();
      n_vec++; if (key_out !== 4'h1) begin n_err++; $display("FAIL release_hold: tick %0d key_out=%h required 1", t, key_out); end
    end
    @(negedge clk);
    n_vec++; if (key_out !== 4'h0)  begin n_err++; $display("FAIL release_key_out: got %h required 0", key_out); end
    n_vec++; if (key_fall !== 4'h1) begin n_err++; $display("FAIL release_fall: got %h required 1", key_fall); end
    n_vec++; if (key_rise !== 4'h0) begin n_err++; $display("FAIL release_rise: got %h required 0", key_rise); end
    @(negedge clk);
    n_vec++; if (key_fall !== 4'h0) begin n_err++; $display("FAIL release_fall_width: got %h required 0", key_fall); end
  endtask

  task automatic test_bounce;
    int r0;
    r0 = rise_cnt[1];
    for (int k = 0; k < 12; k++) begin
      key_in[1] = ~key_in[1];
      repeat (5) begin
        @(negedge clk);
        n_vec++;
        if (key_out !== 4'h0) begin n_err++; $display("FAIL bounce_quiet: toggle %0d key_out=%h required 0", k, key_out); end
      end
    end
    wait_tick();
    key_in[1] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      wait_tick();
      n_vec++; if (key_out !== 4'h0) begin n_err++; $display("FAIL bounce_settle_hold: tick %0d key_out=%h required 0", t, key_out); end
    end
    @(negedge clk);
    n_vec++; if (key_out !== 4'h2)  begin n_err++; $display("FAIL bounce_key_out: got %h required 2", key_out); end
    n_vec++; if (key_rise !== 4'h2) begin n_err++; $display("FAIL bounce_rise: got %h required 2", key_rise); end
    repeat (2) @(negedge clk);
    n_vec++; if (rise_cnt[1] - r0 !== 1) begin n_err++; $display("FAIL bounce_rise_count: got %0d required 1", rise_cnt[1] - r0); end
    key_in[1] = 1'b0;
    wait_ticks(5);
    n_vec++; if (key_out !== 4'h0) begin n_err++; $display("FAIL bounce_release: got %h required 0", key_out); end
  endtask

  task automatic test_glitch;
    wait_tick();
    key_in[2] = 1'b1;
    wait_tick();
    wait_tick();
    key_in[2] = 1'b0;
    wait_tick();
    n_vec++; if (key_out !== 4'h0) begin n_err++; $display("FAIL glitch_no_accept: got %h required 0", key_out); end
    key_in[2] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      wait_tick();
      n_vec++; if (key_out !== 4'h0) begin n_err++; $display("FAIL glitch_restart_hold: tick %0d key_out=%h required 0", t, key_out); end
    end
    @(negedge clk);
    n_vec++; if (key_out !== 4'h4)  begin n_err++; $display("FAIL glitch_key_out: got %h required 4", key_out); end
    n_vec++; if (key_rise !== 4'h4) begin n_err++; $display("FAIL glitch_rise: got %h required 4", key_rise); end
    key_in[2] = 1'b0;
    wait_ticks(5);
    n_vec++; if (key_out !== 4'h0) begin n_err++; $display("FAIL glitch_release: got %h required 0", key_out); end
  endtask

  task automatic test_simultaneous;
    int f1, f3;
    wait_tick();
    key_in = 4'b1010;
    for (int t = 1; t <= 3; t++) begin
      wait_tick();
      n_vec++; if (key_out !== 4'h0) begin n_err++; $display("FAIL simul_hold: tick %0d key_out=%h required 0", t, key_out); end
    end
    @(negedge clk);
    n_vec++; if (key_out !== 4'hA)  begin n_err++; $display("FAIL simul_key_out: got %h required a", key_out); end
    n_vec++; if (key_rise !== 4'hA) begin n_err++; $display("FAIL simul_rise: got %h required a", key_rise); end
    n_vec++; if (key_fall !== 4'h0) begin n_err++; $display("FAIL simul_fall: got %h required 0", key_fall); end
    @(negedge clk);
    n_vec++; if (key_rise !== 4'h0) begin n_err++; $display("FAIL simul_rise_width: got %h required 0", key_rise); end
    f1 = fall_cnt[1];
    f3 = fall_cnt[3];
    key_in = 4'b0000;
    wait_ticks(5);
    n_vec++; if (key_out !== 4'h0) begin n_err++; $display("FAIL simul_release: got %h required 0", key_out); end
    n_vec++;
    if (fall_cnt[1] - f1 !== 1 || fall_cnt[3] - f3 !== 1) begin
      n_err++;
      $display("FAIL simul_fall_count: got ch1=%0d ch3=%0d required 1 1", fall_cnt[1] - f1, fall_cnt[3] - f3);
    end
  endtask

  task automatic test_reset_mid;
    int r0;
    wait_tick();
    key_in[0] = 1'b1;
    wait_ticks(2);
    @(negedge clk);
    r0 = rise_cnt[0];
    rst = 1'b0;
    #1;
    n_vec++; if (key_out !== 4'h0 || key_rise !== 4'h0 || key_fall !== 4'h0 || tick !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_state: key_out=%h rise=%h fall=%h tick=%b required 0 0 0 0", key_out, key_rise, key_fall, tick);
    end
    repeat (3) @(negedge clk);
    n_vec++; if (rise_cnt[0] - r0 !== 0) begin n_err++; $display("FAIL midrst_pulse: got %0d rises required 0", rise_cnt[0] - r0); end
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_vec++;
      if (key_out[0] !== (k >= 12)) begin
        n_err++;
        $display("FAIL midrst_requalify: edge %0d key_out[0]=%b required %b", k, key_out[0], (k >= 12));
      end
    end
    n_vec++; if (key_rise !== 4'h1) begin n_err++; $display("FAIL midrst_rise: got %h required 1", key_rise); end
    key_in[0] = 1'b0;
    wait_ticks(5);
    n_vec++; if (key_out !== 4'h0) begin n_err++; $display("FAIL midrst_release: got %h required 0", key_out); end
  endtask

  task automatic test_variant;
    @(negedge clk);
    n_vec++; if (key_out_v !== 4'hF || key_rise_v !== 4'h0 || key_fall_v !== 4'h0) begin
      n_err++;
      $display("FAIL var_reset: key_out=%h rise=%h fall=%h required f 0 0", key_out_v, key_rise_v, key_fall_v);
    end
    rst_v = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) begin
        n_vec++; if (tick_v !== 1'b1) begin n_err++; $display("FAIL var_first_tick: got %b required 1", tick_v); end
        key_in_v[0] = 1'b0;
      end
      if (k >= 4 && k <= 7) begin
        n_vec++; if (key_out_v !== 4'hF) begin n_err++; $display("FAIL var_hold: edge %0d key_out=%h required f", k, key_out_v); end
      end
      if (k == 8) begin
        n_vec++; if (key_out_v !== 4'hE)  begin n_err++; $display("FAIL var_key_out: got %h required e", key_out_v); end
        n_vec++; if (key_fall_v !== 4'h1) begin n_err++; $display("FAIL var_fall: got %h required 1", key_fall_v); end
        n_vec++; if (key_rise_v !== 4'h0) begin n_err++; $display("FAIL var_rise: got %h required 0", key_rise_v); end
      end
      if (k == 9) begin
        n_vec++; if (key_fall_v !== 4'h0) begin n_err++; $display("FAIL var_fall_width: got %h required 0", key_fall_v); end
        key_in_v[0] = 1'b1;
      end
      if (k == 12) begin
        n_vec++; if (key_out_v !== 4'hF || key_rise_v !== 4'h1) begin
          n_err++;
          $display("FAIL var_rerise: key_out=%h rise=%h required f 1", key_out_v, key_rise_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_variant();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
